// File: rtl/serial_adder4.sv
// serial_adder4 -- bit-serial adder, one full-adder cell plus a carry flop.
//
// Operands are shifted out LSB first, one bit per clock. The sum bits are
// shifted into the MSB of an internal result register, so after WIDTH shifts
// the register holds the sum in normal bit order.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   Start    in   request, accepted in IDLE or DONE
//   A, B     in   [WIDTH-1:0] operands, captured on the accepting edge
//   Cin      in   carry-in, captured on the accepting edge
//   S        out  [WIDTH-1:0] registered sum, updated only at completion
//   Cout     out  registered final carry, updated only at completion
//   Busy     out  high while shifting
//   Done     out  one-cycle completion pulse
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for Start
// SHIFT | one full-adder step per clock, WIDTH steps in total
// DONE  | result on S/Cout is new; Start here chains the next op

module serial_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_shifted;

    assign sum_bit     = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign res_shifted = {sum_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    carry_d = Cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shifted;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Publish from the freshly shifted value so S never
                    // sees a partially built result.
                    s_d     = res_shifted;
                    cout_d  = carry_nxt;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Busy = (state_q == SHIFT);
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder4.sv
// Bench for serial_adder4: a vector table driven through single operations,
// plus hand-written sequences for busy-start, back-to-back and mid-op reset.
// Expected sums are queued when a request is driven and compared when Done
// is seen by the monitor.

module tb_serial_adder4;

    localparam int WIDTH = 4;

    logic             Clock = 1'b0;
    logic             Reset_n;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Busy;
    logic             Done;

    serial_adder4 #(.WIDTH(WIDTH)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .S       (S),
        .Cout    (Cout),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_s;
        logic             exp_cout;
    } vec_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compares the result on every Done pulse and checks that Busy
    // and Done are never high together.
    always @(negedge Clock) begin
        if (Reset_n === 1'b1) begin
            if (Busy && Done) begin
                n_cmp++;
                n_err++;
                $display("FAIL busy_and_done: got both high, expected exclusive (t=%0t)", $time);
            end
            if (Done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got Done with S=%0d Cout=%0d, expected no pulse (t=%0t)",
                             S, Cout, $time);
                end else begin
                    e = sb.pop_front();
                    chk("result_s", int'(S), int'(e.s));
                    chk("result_cout", int'(Cout), int'(e.cout));
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One isolated operation with its cycle-exact Busy/Done profile.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] es, input logic ec);
        exp_t e;
        A = a; B = b; Cin = cin; Start = 1'b1;
        e.s = es; e.cout = ec;
        sb.push_back(e);
        step();
        Start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge Clock);
            chk("op_busy", int'(Busy), 1);
            chk("op_no_done", int'(Done), 0);
        end
        @(negedge Clock);
        chk("op_done", int'(Done), 1);
        step();
        chk("op_done_cleared", int'(Done), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int d0;
        exp_t e;

        vecs[0] = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{4'd9,  4'd9,  1'b1, 4'd3,  1'b1};
        vecs[3] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[5] = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0};
        vecs[6] = '{4'd6,  4'd3,  1'b1, 4'd10, 1'b0};
        vecs[7] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};

        Reset_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #12;
        chk("rst_s", int'(S), 0);
        chk("rst_cout", int'(Cout), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        step();
        Reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_s, vecs[i].exp_cout);
            if (i == 1) begin
                // Result must hold through a long idle stretch.
                for (int k = 0; k < 10; k++) step();
                chk("hold_s", int'(S), 0);
                chk("hold_cout", int'(Cout), 1);
                chk("hold_idle_busy", int'(Busy), 0);
            end
        end

        // Start while busy: second request must be ignored.
        d0 = done_cnt;
        A = 4'd3; B = 4'd4; Cin = 1'b0; Start = 1'b1;
        e.s = 4'd7; e.cout = 1'b0;
        sb.push_back(e);
        step();
        Start = 1'b0;
        step();
        A = 4'd15; B = 4'd15; Start = 1'b1;
        step();
        Start = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("busy_start_one_done", done_cnt - d0, 1);
        chk("busy_start_s", int'(S), 7);

        // Back-to-back with Start held high.
        d0 = done_cnt;
        A = 4'd1; B = 4'd2; Cin = 1'b0; Start = 1'b1;
        e.s = 4'd3; e.cout = 1'b0;
        sb.push_back(e);
        step();
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge Clock);
            chk("b2b_done", int'(Done), (cyc == 5 || cyc == 10) ? 1 : 0);
            chk("b2b_busy", int'(Busy), (cyc == 5 || cyc == 10) ? 0 : 1);
            if (cyc == 5) begin
                A = 4'd5; B = 4'd5;
                e.s = 4'd10; e.cout = 1'b0;
                sb.push_back(e);
            end
            if (cyc == 10) Start = 1'b0;
        end
        step();
        chk("b2b_idle_done", int'(Done), 0);
        chk("b2b_final_s", int'(S), 10);
        chk("b2b_two_done", done_cnt - d0, 2);

        // Reset during the second SHIFT cycle.
        d0 = done_cnt;
        A = 4'd15; B = 4'd15; Cin = 1'b0; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        Reset_n = 1'b0;
        #1;
        chk("midrst_s", int'(S), 0);
        chk("midrst_cout", int'(Cout), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_done", int'(Done), 0);
        step();
        step();
        Reset_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle_s", int'(S), 0);
        run_op(4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        chk("after_rst_s", int'(S), 4);

        for (int k = 0; k < 3; k++) step();
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder4.md
# serial_adder4

Bit-serial 4-bit adder with carry-in and carry-out. It is the additive counterpart of the team's ripple subtractor datapath in the SegurancaDigital arithmetic set. A single full-adder cell and a carry flip-flop process one bit per clock, LSB first. A Start/Busy/Done handshake lets a controller FSM request a sum and wait for the result.

## Interface
- WIDTH, 4, operand and result width in bits; the counter is sized to count 0..WIDTH-1.
- Clock  input  1  single system clock; all state changes on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset; one clock domain.
- Start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- A  input  WIDTH  augend, captured on the accepting edge.
- B  input  WIDTH  addend, captured on the accepting edge.
- Cin  input  1  carry-in, captured on the accepting edge.
- S  output  WIDTH  sum; registered, updated only at completion.
- Cout  output  1  final carry; registered, updated only at completion.
- Busy  output  1  high while in SHIFT.
- Done  output  1  single-cycle pulse in DONE.

## Operation
- States: IDLE, SHIFT, DONE; encoding is free, no illegal-state lockup; unused codes return to IDLE.
- Reset (async assert, any state): state=IDLE; S=0, Cout=0, Busy=0, Done=0; internal operand/shift registers, carry and counter are 0.
- IDLE, Start=1: load A, B into shift registers, load carry FF with Cin, count=0, go to SHIFT.
- IDLE, Start=0: stay.
- SHIFT, each edge:
  - sum bit = a0 ^ b0 ^ c; carry FF <= a0&b0 | c&(a0^b0).
  - Shift A and B right by 1.
  - Shift the sum bit into the MSB of the internal result register, shifting right.
  - count++.
- SHIFT, edge with count=WIDTH-1: copy the completed result to S, the new carry to Cout, go to DONE.
- SHIFT ignores Start; operand inputs are don't-care after capture.
- DONE lasts one cycle; Done=1.
  - Start=1: accept a new operation exactly as from IDLE (back-to-back).
  - Start=0: go to IDLE.
- S and Cout hold their last result through IDLE, DONE and the next SHIFT until the next completion.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1); no overflow flag.

## Timing
- Edge E0 accepts Start.
- Busy=1 in the cycles after edges E0..E(WIDTH-1), i.e. WIDTH cycles (4 by default).
- Edge E(WIDTH) completes the operation.
- Done=1 and the new S/Cout are visible in the cycle after E(WIDTH): latency WIDTH+1 edges from the accepting edge to Done.
- Throughput: one operation per WIDTH+1 cycles with Start held high.
- Busy and Done are never high together; Done is never high for more than one cycle unless a new operation is accepted.
- Reset_n low mid-SHIFT: outputs clear immediately (asynchronous). After release, the first accepted Start is treated as fresh; no partial result ever appears on S.
- Start coincident with reset release: ignored unless Reset_n is high at that edge.

## Test plan
- Basic sum:
  - A=7, B=8, Cin=0, Start pulse.
  - Busy high 4 cycles, then Done 1 cycle with S=15, Cout=0.
- Carry out with zero result:
  - A=15, B=1, Cin=0.
  - S=0, Cout=1 at Done; S and Cout still 0/1 ten cycles later in IDLE.
- Carry-in path:
  - A=9, B=9, Cin=1.
  - S=3, Cout=1; also A=0, B=0, Cin=1 gives S=1, Cout=0.
- Start while Busy:
  - A=3, B=4, then at cycle 2 drive Start=1 with A=15, B=15.
  - Second request ignored; S=7, Cout=0; exactly one Done pulse.
- Back-to-back:
  - Hold Start=1 with A=1, B=2, then A=5, B=5 presented in the DONE cycle.
  - Done pulses at cycles 5 and 10; S=3 then S=10; Busy low only in the DONE cycles.
- Reset mid-operation:
  - A=15, B=15, drop Reset_n during the 2nd SHIFT cycle.
  - S=0, Cout=0, Busy=0, Done=0 immediately, with no Done pulse.
  - A new request A=2, B=2 then yields S=4.
